multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 66 ++++++
 rtl/multicycle_control.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_pkg.sv
// ============================================================================
// Module   : multicycle_control_pkg
// Purpose  : Shared state codes, ALU/mux select codes and opcodes for the
//            multicycle controller, datapath and ALU control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_control_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_R_EXEC    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_I_EXEC    = 4'd10,
    ST_I_WB      = 4'd11,
    ST_TRAP      = 4'd12
  } state_e;

  localparam logic [3:0] c_alu_add   = 4'd0;
  localparam logic [3:0] c_alu_sub   = 4'd1;
  localparam logic [3:0] c_alu_funct = 4'd2;
  localparam logic [3:0] c_alu_or    = 4'd3;
  localparam logic [3:0] c_alu_and   = 4'd4;
  localparam logic [3:0] c_alu_slt   = 4'd5;

  localparam logic [1:0] c_srcb_rt      = 2'd0;
  localparam logic [1:0] c_srcb_four    = 2'd1;
  localparam logic [1:0] c_srcb_imm     = 2'd2;
  localparam logic [1:0] c_srcb_imm_sh2 = 2'd3;

  localparam logic [1:0] c_pcsrc_alu     = 2'd0;
  localparam logic [1:0] c_pcsrc_alu_out = 2'd1;
  localparam logic [1:0] c_pcsrc_jump    = 2'd2;

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_bne   = 6'b000101;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_slti  = 6'b001010;
  localparam logic [5:0] c_op_andi  = 6'b001100;
  localparam logic [5:0] c_op_ori   = 6'b001101;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;

  // ALU operation for the immediate-arithmetic group.
  function automatic logic [3:0] imm_alu_op(input logic [5:0] op);
    case (op)
      c_op_andi: return c_alu_and;
      c_op_ori:  return c_alu_or;
      c_op_slti: return c_alu_slt;
      default:   return c_alu_add;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Purpose  : Multicycle MIPS-subset control FSM with memory wait states,
//            illegal-opcode trap and retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [31:0] instr_count
);

  state_e      r_state;
  state_e      w_next;
  logic [5:0]  r_opcode;
  logic [31:0] r_instr_count;
  logic        w_retire;

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_state       <= ST_FETCH;
      r_opcode      <= 6'd0;
      r_instr_count <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) r_opcode <= opcode;
      if (w_retire) r_instr_count <= r_instr_count + 32'd1;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_retire   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = c_srcb_rt;
    alu_op     = c_alu_add;
    pc_source  = c_pcsrc_alu;
    illegal    = 1'b0;

    case (r_state)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = c_srcb_four;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_b = c_srcb_imm_sh2;
        case (opcode)
          c_op_lw, c_op_sw:                          w_next = ST_MEM_ADDR;
          c_op_rtype:                                w_next = ST_R_EXEC;
          c_op_beq, c_op_bne:                        w_next = ST_BRANCH;
          c_op_j:                                    w_next = ST_JUMP;
          c_op_addi, c_op_andi, c_op_ori, c_op_slti: w_next = ST_I_EXEC;
          default:                                   w_next = ST_TRAP;
        endcase
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = c_srcb_imm;
        w_next    = (r_opcode == c_op_lw) ? ST_MEM_READ : ST_MEM_WRITE;
      end
      ST_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) w_next = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_retire   = 1'b1;
        w_next     = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          w_retire = 1'b1;
          w_next   = ST_FETCH;
        end
      end
      ST_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = c_alu_funct;
        w_next    = ST_R_WB;
      end
      ST_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        w_retire  = 1'b1;
        w_next    = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = c_alu_sub;
        pc_source = c_pcsrc_alu_out;
        pc_write  = ((r_opcode == c_op_beq) && zero) ||
                    ((r_opcode == c_op_bne) && !zero);
        w_retire  = 1'b1;
        w_next    = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = c_pcsrc_jump;
        w_retire  = 1'b1;
        w_next    = ST_FETCH;
      end
      ST_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = c_srcb_imm;
        alu_op    = imm_alu_op(r_opcode);
        w_next    = ST_I_WB;
      end
      ST_I_WB: begin
        reg_write = 1'b1;
        w_retire  = 1'b1;
        w_next    = ST_FETCH;
      end
      // ST_TRAP and the unused codes 13-15 all lock up here.
      default: begin
        illegal = 1'b1;
        w_next  = ST_TRAP;
      end
    endcase

    // The state register already reads FETCH under reset; gate its strobes too.
    if (nrst) begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = c_srcb_rt;
      alu_op     = c_alu_add;
      pc_source  = c_pcsrc_alu;
      illegal    = 1'b0;
    end
  end

  assign state       = r_state;
  assign instr_count = r_instr_count;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Table-driven, scoreboarded testbench for multicycle_control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        nrst;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_read, mem_write, iord, ir_write, pc_write, reg_write;
  logic        reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0]  alu_src_b, pc_source;
  logic [3:0]  alu_op, state;
  logic [31:0] instr_count;

  multicycle_control dut (
    .clk(clk), .nrst(nrst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .state(state), .illegal(illegal),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // {mem_read,mem_write,iord,ir_write,pc_write,reg_write,reg_dst,mem_to_reg,
  //  alu_src_a,alu_src_b,alu_op,pc_source,illegal}
  logic [17:0] w_ctrl;
  assign w_ctrl = {mem_read, mem_write, iord, ir_write, pc_write, reg_write, reg_dst,
                   mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, illegal};

  localparam logic [17:0] K_FETCH    = {8'b1000_0000, 1'b0, 2'd1, 4'd0, 2'd0, 1'b0};
  localparam logic [17:0] K_FETCH_GO = {8'b1001_1000, 1'b0, 2'd1, 4'd0, 2'd0, 1'b0};
  localparam logic [17:0] K_DECODE   = {8'b0000_0000, 1'b0, 2'd3, 4'd0, 2'd0, 1'b0};
  localparam logic [17:0] K_MADDR    = {8'b0000_0000, 1'b1, 2'd2, 4'd0, 2'd0, 1'b0};
  localparam logic [17:0] K_MREAD    = {8'b1010_0000, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0};
  localparam logic [17:0] K_MWB      = {8'b0000_0101, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0};
  localparam logic [17:0] K_MWRITE   = {8'b0110_0000, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0};
  localparam logic [17:0] K_REX      = {8'b0000_0000, 1'b1, 2'd0, 4'd2, 2'd0, 1'b0};
  localparam logic [17:0] K_RWB      = {8'b0000_0110, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0};
  localparam logic [17:0] K_BR_T     = {8'b0000_1000, 1'b1, 2'd0, 4'd1, 2'd1, 1'b0};
  localparam logic [17:0] K_BR_N     = {8'b0000_0000, 1'b1, 2'd0, 4'd1, 2'd1, 1'b0};
  localparam logic [17:0] K_JUMP     = {8'b0000_1000, 1'b0, 2'd0, 4'd0, 2'd2, 1'b0};
  localparam logic [17:0] K_IWB      = {8'b0000_0100, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0};
  localparam logic [17:0] K_TRAP     = {17'd0, 1'b1};

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B, OP_BAD = 6'h3F;

  function automatic logic [17:0] k_iex(input logic [3:0] op);
    return {8'b0000_0000, 1'b1, 2'd2, op, 2'd0, 1'b0};
  endfunction

  typedef struct packed {
    logic [5:0]  op;
    logic        z;
    logic        rdy;
    logic [3:0]  exp_state;
    logic [17:0] exp_ctrl;
    logic [31:0] exp_count;
  } vec_t;

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] ctl;
    logic [31:0] cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic void v(input logic [5:0] op, input logic z, input logic rdy,
                            input logic [3:0] st, input logic [17:0] ctl,
                            input logic [31:0] cnt);
    vecs.push_back('{op, z, rdy, st, ctl, cnt});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Each vector occupies one clock cycle: inputs driven just after the
  // rising edge, outputs compared on the falling edge.
  task automatic run_vecs(input string tag);
    exp_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      opcode    = vecs[i].op;
      zero      = vecs[i].z;
      mem_ready = vecs[i].rdy;
      sb.push_back('{vecs[i].exp_state, vecs[i].exp_ctrl, vecs[i].exp_count});
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("%s[%0d].state", tag, i), {28'd0, state}, {28'd0, e.st});
      check($sformatf("%s[%0d].ctrl", tag, i), {14'd0, w_ctrl}, {14'd0, e.ctl});
      check($sformatf("%s[%0d].count", tag, i), instr_count, e.cnt);
    end
    vecs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b1; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check("reset.state", {28'd0, state}, 32'd0);
    check("reset.ctrl", {14'd0, w_ctrl}, 32'd0);
    check("reset.count", instr_count, 32'd0);
    @(negedge clk);
    #1 nrst = 1'b0;

    // R-type, j, ori back to back; later-state opcode inputs are junk.
    v(OP_R, 0, 1, 0, K_FETCH_GO, 0);  v(OP_R, 0, 1, 1, K_DECODE, 0);
    v(OP_BAD, 0, 1, 6, K_REX, 0);     v(OP_BAD, 0, 0, 7, K_RWB, 0);
    v(OP_J, 0, 1, 0, K_FETCH_GO, 1);  v(OP_J, 0, 1, 1, K_DECODE, 1);
    v(OP_J, 0, 0, 9, K_JUMP, 1);
    v(OP_ORI, 0, 1, 0, K_FETCH_GO, 2); v(OP_ORI, 0, 0, 1, K_DECODE, 2);
    v(OP_LW, 0, 0, 10, k_iex(4'd3), 2); v(OP_LW, 0, 1, 11, K_IWB, 2);
    run_vecs("rjo");

    // lw with two wait cycles on each memory access.
    v(OP_LW, 0, 0, 0, K_FETCH, 3);    v(OP_LW, 0, 0, 0, K_FETCH, 3);
    v(OP_LW, 0, 1, 0, K_FETCH_GO, 3); v(OP_LW, 0, 0, 1, K_DECODE, 3);
    v(OP_SW, 0, 1, 2, K_MADDR, 3);
    v(OP_BAD, 0, 0, 3, K_MREAD, 3);   v(OP_BAD, 0, 0, 3, K_MREAD, 3);
    v(OP_BAD, 0, 1, 3, K_MREAD, 3);   v(OP_BAD, 0, 0, 4, K_MWB, 3);
    run_vecs("lw");

    // Branches (opposite opcode on the input during BRANCH), immediates, sw.
    v(OP_BEQ, 1, 1, 0, K_FETCH_GO, 4); v(OP_BEQ, 1, 1, 1, K_DECODE, 4);
    v(OP_BNE, 1, 1, 8, K_BR_T, 4);
    v(OP_BEQ, 0, 1, 0, K_FETCH_GO, 5); v(OP_BEQ, 0, 1, 1, K_DECODE, 5);
    v(OP_BNE, 0, 1, 8, K_BR_N, 5);
    v(OP_BNE, 0, 1, 0, K_FETCH_GO, 6); v(OP_BNE, 0, 1, 1, K_DECODE, 6);
    v(OP_BEQ, 0, 1, 8, K_BR_T, 6);
    v(OP_BNE, 1, 1, 0, K_FETCH_GO, 7); v(OP_BNE, 1, 1, 1, K_DECODE, 7);
    v(OP_BEQ, 1, 1, 8, K_BR_N, 7);
    v(OP_ADDI, 0, 1, 0, K_FETCH_GO, 8); v(OP_ADDI, 0, 1, 1, K_DECODE, 8);
    v(OP_ANDI, 0, 1, 10, k_iex(4'd0), 8); v(OP_ANDI, 0, 1, 11, K_IWB, 8);
    v(OP_ANDI, 0, 1, 0, K_FETCH_GO, 9); v(OP_ANDI, 0, 1, 1, K_DECODE, 9);
    v(OP_ORI, 0, 1, 10, k_iex(4'd4), 9); v(OP_ORI, 0, 1, 11, K_IWB, 9);
    v(OP_SLTI, 0, 1, 0, K_FETCH_GO, 10); v(OP_SLTI, 0, 1, 1, K_DECODE, 10);
    v(OP_ADDI, 0, 1, 10, k_iex(4'd5), 10); v(OP_ADDI, 0, 1, 11, K_IWB, 10);
    v(OP_SW, 0, 1, 0, K_FETCH_GO, 11); v(OP_SW, 0, 1, 1, K_DECODE, 11);
    v(OP_LW, 0, 1, 2, K_MADDR, 11);
    v(OP_LW, 0, 0, 5, K_MWRITE, 11);   v(OP_LW, 0, 1, 5, K_MWRITE, 11);
    // Illegal opcode: trap holds with no strobes regardless of inputs.
    v(OP_BAD, 0, 1, 0, K_FETCH_GO, 12); v(OP_BAD, 0, 1, 1, K_DECODE, 12);
    for (int i = 0; i < 20; i++)
      v(6'($urandom), 1'($urandom), 1'($urandom), 12, K_TRAP, 12);
    run_vecs("mix");

    // Reset out of TRAP.
    #2 nrst = 1'b1;
    #1;
    check("trapreset.state", {28'd0, state}, 32'd0);
    check("trapreset.ctrl", {14'd0, w_ctrl}, 32'd0);
    @(negedge clk);
    check("trapreset.count", instr_count, 32'd0);
    mem_ready = 1'b0;
    #1 nrst = 1'b0;

    // sw stalled in MEM_WRITE, then reset mid-access.
    v(OP_SW, 0, 1, 0, K_FETCH_GO, 0); v(OP_SW, 0, 1, 1, K_DECODE, 0);
    v(OP_SW, 0, 0, 2, K_MADDR, 0);    v(OP_SW, 0, 0, 5, K_MWRITE, 0);
    run_vecs("swpre");
    #2 nrst = 1'b1;
    #1;
    check("abort.mem_write", {31'd0, mem_write}, 32'd0);
    check("abort.state", {28'd0, state}, 32'd0);
    check("abort.ctrl", {14'd0, w_ctrl}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1 nrst = 1'b0;
    v(OP_SW, 0, 0, 0, K_FETCH, 0);
    run_vecs("swpost");

    // Counter wrap.
    force dut.r_instr_count = 32'hFFFF_FFFF;
    #1 release dut.r_instr_count;
    v(OP_J, 0, 1, 0, K_FETCH_GO, 32'hFFFF_FFFF); v(OP_J, 0, 1, 1, K_DECODE, 32'hFFFF_FFFF);
    v(OP_J, 0, 0, 9, K_JUMP, 32'hFFFF_FFFF);     v(OP_J, 0, 0, 0, K_FETCH, 32'h0000_0000);
    run_vecs("wrap");

    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
